// File: rtl/hyper_ca_serializer.sv
`default_nettype none
// ============================================================================
// Module   : hyper_ca_serializer
// Purpose  : Drives a 48-bit HyperBus command-address word onto DQ as three
//            16-bit DDR words, frames it with chip select, and holds the bus
//            until the data-phase engine reports the end of the transaction.
//            Reports whether the device asked for doubled initial latency.
// Ports    : clk_i, rst_i (async, active high)
//            cmd_addr_i/cmd_valid_i/cmd_ready_o : CA word handshake
//            abort_i    : abandon the current transaction (highest priority)
//            txn_end_i  : data phase finished, release CS
//            rwds_i     : synchronised RWDS, sampled during the first CA word
//            dq_o/dq_oe_o/cs_no : HyperBus CA drive towards the PHY
//            ca_done_o  : one-cycle pulse after the last CA word
//            latency_double_o : 1 = 2x initial latency requested
//            busy_o     : block is not idle
// Macro    : HYPER_RWDS_LATENCY_SAMPLE_EN - when defined, latency_double_o
//            comes from RWDS sampled during CA word 0; otherwise it takes
//            FIXED_LATENCY_DOUBLE.
// Revision : 1.0 - initial release
// ============================================================================
module hyper_ca_serializer #(
    parameter int unsigned CS_SETUP_CYCLES      = 1,
    parameter logic        FIXED_LATENCY_DOUBLE = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [47:0] cmd_addr_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        abort_i,
    input  logic        txn_end_i,
    input  logic        rwds_i,
    output logic [15:0] dq_o,
    output logic        dq_oe_o,
    output logic        cs_no,
    output logic        ca_done_o,
    output logic        latency_double_o,
    output logic        busy_o
);

    localparam logic [1:0] c_IDLE     = 2'd0;
    localparam logic [1:0] c_SETUP    = 2'd1;
    localparam logic [1:0] c_SHIFT    = 2'd2;
    localparam logic [1:0] c_WAIT_END = 2'd3;

    // Setup counter counts down to zero, so it starts one below the cycle count.
    localparam logic [2:0] c_SETUP_LOAD =
        (CS_SETUP_CYCLES > 0) ? 3'(CS_SETUP_CYCLES - 1) : 3'd0;

    logic [1:0]  state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [1:0]  idx_q, idx_d;
    logic [47:0] ca_q;
    logic        ca_done_q;
    logic        lat_q;
    logic        w_accept;
    logic        w_shift_last;
    logic        w_lat_sample;

    // cmd_ready_o is ~abort_i in IDLE, so acceptance excludes abort.
    assign w_accept     = (state_q == c_IDLE) && cmd_valid_i && !abort_i;
    // Final CA word leaving SHIFT normally (an abort suppresses ca_done_o).
    assign w_shift_last = (state_q == c_SHIFT) && (idx_q == 2'd2) && !abort_i;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= c_IDLE;
            cnt_q   <= 3'd0;
            idx_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        if (abort_i) begin
            state_d = c_IDLE;
        end else begin
            case (state_q)
                c_IDLE: begin
                    if (cmd_valid_i) begin
                        idx_d   = 2'd0;
                        cnt_d   = c_SETUP_LOAD;
                        state_d = (CS_SETUP_CYCLES > 0) ? c_SETUP : c_SHIFT;
                    end
                end
                c_SETUP: begin
                    if (cnt_q == 3'd0) begin
                        state_d = c_SHIFT;
                    end else begin
                        cnt_d = cnt_q - 3'd1;
                    end
                end
                c_SHIFT: begin
                    if (idx_q == 2'd2) begin
                        state_d = c_WAIT_END;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
                c_WAIT_END: begin
                    // Also honoured in the ca_done_o cycle; the pulse is registered.
                    if (txn_end_i) begin
                        state_d = c_IDLE;
                    end
                end
                default: state_d = c_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output decode
    // ------------------------------------------------------------------
    always_comb begin
        cmd_ready_o = 1'b0;
        cs_no       = 1'b0;
        dq_o        = 16'd0;
        dq_oe_o     = 1'b0;
        busy_o      = 1'b1;
        case (state_q)
            c_IDLE: begin
                cmd_ready_o = ~abort_i;
                cs_no       = 1'b1;
                busy_o      = 1'b0;
            end
            c_SHIFT: begin
                dq_oe_o = 1'b1;
                case (idx_q)
                    2'd0:    dq_o = ca_q[47:32];
                    2'd1:    dq_o = ca_q[31:16];
                    default: dq_o = ca_q[15:0];
                endcase
            end
            default: ;
        endcase
    end

    assign ca_done_o        = ca_done_q;
    assign latency_double_o = lat_q;

    // ------------------------------------------------------------------
    // Datapath registers: CA word, done pulse, latency flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ca_q      <= 48'd0;
            ca_done_q <= 1'b0;
            lat_q     <= 1'b0;
        end else begin
            ca_done_q <= w_shift_last;
            if (w_accept) begin
                ca_q <= cmd_addr_i;
            end
            if (abort_i || w_accept) begin
                lat_q <= 1'b0;
            end else if (w_shift_last) begin
                lat_q <= w_lat_sample;
            end
        end
    end

`ifdef HYPER_RWDS_LATENCY_SAMPLE_EN
    // RWDS is captured while CA word 0 is on the bus and published with ca_done_o.
    logic rwds_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rwds_q <= 1'b0;
        end else if ((state_q == c_SHIFT) && (idx_q == 2'd0)) begin
            rwds_q <= rwds_i;
        end
    end

    assign w_lat_sample = rwds_q;
`else
    logic w_unused_rwds;

    assign w_unused_rwds = rwds_i;
    assign w_lat_sample  = FIXED_LATENCY_DOUBLE;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hyper_ca_serializer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_hyper_ca_serializer
// Purpose  : Self-checking bench for hyper_ca_serializer. Two instances
//            (CS_SETUP_CYCLES=1 and 0) share one stimulus stream; a
//            cycle-age model predicts every output each cycle, and directed
//            scenarios add literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hyper_ca_serializer;

    localparam logic FIXED_LAT = 1'b1;
`ifdef HYPER_RWDS_LATENCY_SAMPLE_EN
    localparam logic SAMPLE_EN = 1'b1;
`else
    localparam logic SAMPLE_EN = 1'b0;
`endif

    logic        clk_i       = 1'b0;
    logic        rst_i       = 1'b1;
    logic [47:0] cmd_addr_i  = 48'd0;
    logic        cmd_valid_i = 1'b0;
    logic        abort_i     = 1'b0;
    logic        txn_end_i   = 1'b0;
    logic        rwds_i      = 1'b0;

    logic [1:0]  ready_w, oe_w, cs_w, done_w, lat_w, busy_w;
    logic [15:0] dq_w [2];

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk_i = ~clk_i;

    // Instance 0: one setup cycle; instance 1: no setup cycles.
    hyper_ca_serializer #(.CS_SETUP_CYCLES(1), .FIXED_LATENCY_DOUBLE(FIXED_LAT)) u_dut_s1 (
        .clk_i(clk_i), .rst_i(rst_i), .cmd_addr_i(cmd_addr_i), .cmd_valid_i(cmd_valid_i),
        .cmd_ready_o(ready_w[0]), .abort_i(abort_i), .txn_end_i(txn_end_i), .rwds_i(rwds_i),
        .dq_o(dq_w[0]), .dq_oe_o(oe_w[0]), .cs_no(cs_w[0]), .ca_done_o(done_w[0]),
        .latency_double_o(lat_w[0]), .busy_o(busy_w[0])
    );

    hyper_ca_serializer #(.CS_SETUP_CYCLES(0), .FIXED_LATENCY_DOUBLE(FIXED_LAT)) u_dut_s0 (
        .clk_i(clk_i), .rst_i(rst_i), .cmd_addr_i(cmd_addr_i), .cmd_valid_i(cmd_valid_i),
        .cmd_ready_o(ready_w[1]), .abort_i(abort_i), .txn_end_i(txn_end_i), .rwds_i(rwds_i),
        .dq_o(dq_w[1]), .dq_oe_o(oe_w[1]), .cs_no(cs_w[1]), .ca_done_o(done_w[1]),
        .latency_double_o(lat_w[1]), .busy_o(busy_w[1])
    );

    function automatic void check1(input string name, input logic act, input logic exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %04h expected %04h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic int setup_of(input int i);
        return (i == 0) ? 1 : 0;
    endfunction

    // ------------------------------------------------------------------
    // Reference model: age = cycles since acceptance (0 = idle).
    // Ages 1..S are setup, S+1..S+3 carry the CA words, S+4 is the
    // ca_done cycle, beyond that the bus is held until txn_end.
    // ------------------------------------------------------------------
    int          m_age  [2];
    logic [47:0] m_ca   [2];
    logic        m_lat  [2];
    logic        m_rwds [2];

    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < 2; i++) begin
                m_age[i]  <= 0;
                m_ca[i]   <= 48'd0;
                m_lat[i]  <= 1'b0;
                m_rwds[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (abort_i) begin
                    m_age[i] <= 0;
                    m_lat[i] <= 1'b0;
                end else if (m_age[i] == 0) begin
                    if (cmd_valid_i) begin
                        m_age[i] <= 1;
                        m_ca[i]  <= cmd_addr_i;
                        m_lat[i] <= 1'b0;
                    end
                end else begin
                    if (m_age[i] == setup_of(i) + 1) m_rwds[i] <= rwds_i;
                    if (m_age[i] == setup_of(i) + 3) m_lat[i] <= SAMPLE_EN ? m_rwds[i] : FIXED_LAT;
                    if (m_age[i] >= setup_of(i) + 4 && txn_end_i) m_age[i] <= 0;
                    else if (m_age[i] < setup_of(i) + 5) m_age[i] <= m_age[i] + 1;
                end
            end
        end
    end

    function automatic void check_inst(input int i);
        int s, a, w;
        logic [15:0] e_dq;
        logic e_oe, e_done, e_cs, e_ready, e_busy;
        s = setup_of(i);
        a = m_age[i];
        e_dq = 16'd0; e_oe = 1'b0; e_done = 1'b0;
        if (a == 0) begin
            e_ready = !abort_i; e_cs = 1'b1; e_busy = 1'b0;
        end else begin
            e_ready = 1'b0; e_cs = 1'b0; e_busy = 1'b1;
            if (a >= s + 1 && a <= s + 3) begin
                w    = a - s - 1;
                e_oe = 1'b1;
                e_dq = 16'(m_ca[i] >> (16 * (2 - w)));
            end
            e_done = (a == s + 4);
        end
        check1($sformatf("model ready[%0d]", i), ready_w[i], e_ready);
        check1($sformatf("model cs_no[%0d]", i), cs_w[i], e_cs);
        check1($sformatf("model busy[%0d]", i), busy_w[i], e_busy);
        check1($sformatf("model dq_oe[%0d]", i), oe_w[i], e_oe);
        check16($sformatf("model dq[%0d]", i), dq_w[i], e_dq);
        check1($sformatf("model ca_done[%0d]", i), done_w[i], e_done);
        check1($sformatf("model lat[%0d]", i), lat_w[i], m_lat[i]);
    endfunction

    always @(negedge clk_i) begin
        if (!rst_i) begin
            check_inst(0);
            check_inst(1);
        end
    end

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic smp();
        @(negedge clk_i);
    endtask

    logic exp_lat;

    initial begin
        // Reset values
        smp();
        check1("rst ready", ready_w[0], 1'b1);
        check1("rst cs_no", cs_w[0], 1'b1);
        check16("rst dq", dq_w[0], 16'h0000);
        check1("rst dq_oe", oe_w[0], 1'b0);
        check1("rst ca_done", done_w[0], 1'b0);
        check1("rst lat", lat_w[0], 1'b0);
        check1("rst busy", busy_w[0], 1'b0);
        cyc(); rst_i = 1'b0;
        cyc();

        // Basic CA sequence, RWDS high during word 0 of the setup-1 instance
        cmd_addr_i = 48'hA0123456789A; cmd_valid_i = 1'b1;
        smp(); check1("s1 ready T", ready_w[0], 1'b1);
        cyc(); cmd_valid_i = 1'b0;
        smp(); check1("s1 cs T+1", cs_w[0], 1'b0); check1("s1 ready T+1", ready_w[0], 1'b0);
        check1("s1 oe T+1", oe_w[0], 1'b0); check16("s6 dq0 T+1", dq_w[1], 16'hA012);
        cyc(); rwds_i = 1'b1;
        smp(); check16("s1 w0", dq_w[0], 16'hA012); check1("s1 oe w0", oe_w[0], 1'b1);
        check16("s6 w1", dq_w[1], 16'h3456);
        cyc(); rwds_i = 1'b0;
        smp(); check16("s1 w1", dq_w[0], 16'h3456); check16("s6 w2", dq_w[1], 16'h789A);
        cyc();
        smp(); check16("s1 w2", dq_w[0], 16'h789A); check1("s6 done", done_w[1], 1'b1);
        cyc();
        exp_lat = SAMPLE_EN ? 1'b1 : FIXED_LAT;
        smp(); check1("s1 done", done_w[0], 1'b1); check1("s1 oe off", oe_w[0], 1'b0);
        check16("s1 dq off", dq_w[0], 16'h0000); check1("s1 cs held", cs_w[0], 1'b0);
        check1("s2 lat rwds1", lat_w[0], exp_lat);
        cyc(); txn_end_i = 1'b1;
        smp(); check1("s1 done once", done_w[0], 1'b0);
        cyc(); txn_end_i = 1'b0;
        smp(); check1("s1 cs release", cs_w[0], 1'b1); check1("s1 idle", busy_w[0], 1'b0);
        check1("s1 lat held", lat_w[0], exp_lat);

        // Abort during SHIFT word 1
        cyc(); cmd_addr_i = 48'h0F0E0D0C0B0A; cmd_valid_i = 1'b1;
        cyc(); cmd_valid_i = 1'b0;
        smp(); check1("s3 lat cleared", lat_w[0], 1'b0);
        cyc();
        cyc(); abort_i = 1'b1;
        smp(); check16("s3 w1", dq_w[0], 16'h0D0C); check1("s3 ready abort", ready_w[0], 1'b0);
        cyc(); abort_i = 1'b0;
        smp(); check1("s3 cs", cs_w[0], 1'b1); check1("s3 oe", oe_w[0], 1'b0);
        check1("s3 ready", ready_w[0], 1'b1);
        cyc();
        smp(); check1("s3 no done", done_w[0], 1'b0);

        // Valid with abort in IDLE
        cyc(); cmd_addr_i = 48'h555555555555; cmd_valid_i = 1'b1; abort_i = 1'b1;
        smp(); check1("s4 ready", ready_w[0], 1'b0);
        cyc(); cmd_valid_i = 1'b0; abort_i = 1'b0;
        smp(); check1("s4 cs", cs_w[0], 1'b1); check1("s4 busy", busy_w[0], 1'b0);

        // txn_end coincident with ca_done, then back-to-back command
        cyc(); cmd_addr_i = 48'h123456789ABC; cmd_valid_i = 1'b1;
        cyc(); cmd_valid_i = 1'b0;
        cyc(); cyc(); cyc();
        cyc(); txn_end_i = 1'b1;
        smp(); check1("s5 done", done_w[0], 1'b1);
        cyc(); txn_end_i = 1'b0; cmd_addr_i = 48'hFEDCBA987654; cmd_valid_i = 1'b1;
        smp(); check1("s5 cs idle", cs_w[0], 1'b1); check1("s5 ready", ready_w[0], 1'b1);
        cyc(); cmd_valid_i = 1'b0;
        smp(); check1("s5 cs low", cs_w[0], 1'b0);
        cyc(); smp(); check16("s5 w0", dq_w[0], 16'hFEDC);
        cyc(); smp(); check16("s5 w1", dq_w[0], 16'hBA98);
        cyc(); smp(); check16("s5 w2", dq_w[0], 16'h7654);
        cyc();
        exp_lat = SAMPLE_EN ? 1'b0 : FIXED_LAT;
        smp(); check1("s5 done2", done_w[0], 1'b1); check1("s2 lat rwds0", lat_w[0], exp_lat);

        // Asynchronous reset in WAIT_END
        cyc();
        #1 rst_i = 1'b1;
        #1;
        check1("s6 rst cs0", cs_w[0], 1'b1); check1("s6 rst cs1", cs_w[1], 1'b1);
        check1("s6 rst busy", busy_w[0], 1'b0); check1("s6 rst lat", lat_w[0], 1'b0);
        check1("s6 rst ready", ready_w[0], 1'b1);
        cyc(); rst_i = 1'b0;

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            cyc();
            cmd_valid_i = ($urandom_range(0, 3) != 0);
            cmd_addr_i  = {16'($urandom), $urandom};
            abort_i     = ($urandom_range(0, 19) == 0);
            txn_end_i   = ($urandom_range(0, 3) == 0);
            rwds_i      = 1'($urandom);
        end
        cyc();
        smp();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
